inst_mem_fetch: RTL

- Parametrised instruction memory with a valid/ready fetch interface, replacing the flat combinational instruction ROM.
- Sits between the PC/fetch stage and the decode stage.
- Provides a testbench/boot load port, configurable read latency and fault reporting for misaligned and out-of-range PCs.
- Buffers responses under decode backpressure and supports a flush on branch redirect.

---
 rtl/inst_mem_pkg.sv | 22 ++
 rtl/inst_rsp_fifo.sv | 58 +++++
 rtl/inst_mem_fetch.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction memory fetch block.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    FAULT_OK       = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_e;

  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  // Default response entry for an RV32 core; other widths pass their own type.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   addr;
    fault_e            fault;
  } rsp_t;

endpackage : inst_mem_pkg

// File: rtl/inst_rsp_fifo.sv
// Small first-word-fall-through FIFO for fetch responses; head is always entry 0.
module inst_rsp_fifo
  import inst_mem_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = rsp_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush_i,
  input  logic   push_i,
  input  entry_t wdata_i,
  input  logic   pop_i,
  output entry_t rdata_o,
  output logic   empty_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wr_idx;

  // A push in a pop cycle lands one slot lower because the entries shift down.
  assign wr_idx = cnt_q - CNT_W'(pop_i);

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      if (pop_i) begin
        for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i + 1];
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (push_i && (wr_idx == CNT_W'(i))) mem_d[i] = wdata_i;
      end
      cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // NOTE: storage is deliberately not reset; only the count defines validity,
  // which keeps the data flops free of reset routing.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign rdata_o = mem_q[0];
  assign empty_o = (cnt_q == '0);

endmodule : inst_rsp_fifo

// File: rtl/inst_mem_fetch.sv
// Instruction memory with valid/ready fetch, boot load port, fault reporting,
// credit-based backpressure and branch-redirect flush.
module inst_mem_fetch
  import inst_mem_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter int                DEPTH      = 16,
  parameter int                READ_LAT   = 1,
  parameter logic [DATA_W-1:0] RESET_INST = DATA_W'(RV32I_NOP)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_err,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_inst,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [1:0]        rsp_fault
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int FIFO_D = READ_LAT + 1;
  localparam int CNT_W  = $clog2(READ_LAT + 2);

  typedef struct packed {
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] addr;
    fault_e            fault;
  } entry_t;

  function automatic fault_e decode_fault(input logic [ADDR_W-1:0] a);
    if (a[1:0] != 2'b00)           return FAULT_MISALIGN;
    if (a >= ADDR_W'(DEPTH * 4))   return FAULT_RANGE;
    return FAULT_OK;
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              load_ok;
  logic              load_err_q;
  fault_e            load_fault;
  fault_e            req_fault;
  entry_t            rd_entry;
  entry_t            push_data;
  entry_t            head;
  logic              accept;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [CNT_W-1:0]  out_q, out_d;

  // Load port: illegal addresses are dropped and reported one cycle later.
  assign load_fault = decode_fault(load_addr);
  assign load_ok    = load_en && (load_fault == FAULT_OK);

  always_ff @(posedge clk) begin
    if (load_ok) mem_q[load_addr[IDX_W+1:2]] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) load_err_q <= 1'b0;
    else        load_err_q <= load_en && !load_ok;
  end

  assign load_err = load_err_q;

  // Loads and flushes take the array/pipeline for the cycle, so fetch stalls.
  assign req_ready = (out_q < CNT_W'(READ_LAT + 1)) && !load_en && !flush && rst_n;
  assign accept    = req_valid && req_ready;
  assign req_fault = decode_fault(req_addr);

  always_comb begin
    rd_entry       = '0;
    rd_entry.addr  = req_addr;
    rd_entry.fault = req_fault;
    rd_entry.inst  = (req_fault == FAULT_OK) ? mem_q[req_addr[IDX_W+1:2]] : RESET_INST;
  end

  if (READ_LAT == 1) begin : g_lat1
    assign push      = accept;
    assign push_data = rd_entry;
  end else begin : g_lat2
    logic   stage_valid_q;
    entry_t stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_valid_q <= 1'b0;
        stage_q       <= '0;
      end else if (flush) begin
        stage_valid_q <= 1'b0;
      end else begin
        stage_valid_q <= accept;
        stage_q       <= rd_entry;
      end
    end

    assign push      = stage_valid_q;
    assign push_data = stage_q;
  end

  inst_rsp_fifo #(
    .DEPTH   (FIFO_D),
    .entry_t (entry_t)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (fifo_empty)
  );

  // Credits cover the stage register plus the FIFO, so the FIFO cannot overflow.
  always_comb begin
    out_d = out_q;
    if (flush) out_d = '0;
    else       out_d = out_q + CNT_W'(accept) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_inst  = rsp_valid ? head.inst  : RESET_INST;
  assign rsp_addr  = rsp_valid ? head.addr  : '0;
  assign rsp_fault = rsp_valid ? head.fault : FAULT_OK;

endmodule : inst_mem_fetch
